// File: rtl/chart_sequencer.sv
// chart_sequencer
//   Note-chart player feeding the serial note input of a scrolling lane
//   renderer. A small chart of {end_flag, gap} entries is played back as a
//   one-bit note stream, one bit per scroll step. Each note is held high for
//   BLOCK_LEN steps so the lane draws a full block.
//
// Ports
//   clk        pixel clock
//   rst        synchronous active-high reset
//   wr_en      chart write strobe (accepted only while not busy)
//   wr_addr    chart write address
//   wr_data    chart entry {end_flag[8], gap[7:0]}
//   start      pulse: begin playback at entry 0
//   stop       pulse: abort playback (wins over start)
//   loop_en    restart at entry 0 at end of chart instead of finishing
//   note_out   serial note bit to lane
//   step       one-cycle strobe per scroll step (lane shift enable)
//   busy       high while playing (GAP/NOTE)
//   done       high after the chart finished, until start or rst
//   note_count notes completed since start, saturating at 255
module chart_sequencer #(
  parameter int CHART_DEPTH = 64,
  parameter int TICK_DIV    = 1,
  parameter int BLOCK_LEN   = 5,
  localparam int AW = (CHART_DEPTH > 1) ? $clog2(CHART_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [8:0]    wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic          note_out,
  output logic          step,
  output logic          busy,
  output logic          done,
  output logic [7:0]    note_count
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(BLOCK_LEN - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(CHART_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, GAP, NOTE, DONE} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [AW-1:0] addr;
  logic [7:0]    gap_cnt;
  logic [HW-1:0] hold_cnt;

  logic [8:0]    chart_mem [CHART_DEPTH];

  // Chart write port; a non-power-of-two depth needs an explicit range check.
  logic addr_ok;
  if ((1 << AW) == CHART_DEPTH) begin : g_full_range
    assign addr_ok = 1'b1;
  end else begin : g_part_range
    assign addr_ok = (int'(wr_addr) < CHART_DEPTH);
  end

  // NOTE: the chart array has no reset; its contents survive rst by design
  // and leaving it out lets the tools map it to plain storage.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && addr_ok) begin
      chart_mem[wr_addr] <= wr_data;
    end
  end

  // Combinational chart reads at the current and following address.
  logic [AW-1:0] addr_inc;
  logic          end_flag;
  logic [7:0]    next_gap;
  logic [7:0]    first_gap;
  logic          end_of_chart;

  assign addr_inc     = addr + 1'b1;
  assign end_flag     = chart_mem[addr][8];
  assign next_gap     = chart_mem[addr_inc][7:0];
  assign first_gap    = chart_mem[0][7:0];
  assign end_of_chart = end_flag || (addr == ADDR_LAST);

  // The step strobe is registered, so it is computed from the divider's next
  // value: step is high exactly in the cycle where div_cnt == TICK_DIV-1.
  logic [DW-1:0] div_next;
  assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

  // NOTE: all state updates use non-blocking assignments; later assignments
  // in this block intentionally override the earlier defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      addr       <= '0;
      gap_cnt    <= '0;
      hold_cnt   <= '0;
      note_out   <= 1'b0;
      step       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      note_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start && !stop) begin
            state      <= GAP;
            addr       <= '0;
            gap_cnt    <= first_gap;
            note_count <= '0;
            div_cnt    <= '0;
            step       <= (DIV_LAST == '0);
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end

        GAP, NOTE: begin
          if (stop) begin
            state    <= IDLE;
            note_out <= 1'b0;
            step     <= 1'b0;
            div_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else begin
            div_cnt <= div_next;
            step    <= (div_next == DIV_LAST);
            if (step) begin
              if (state == GAP) begin
                if (gap_cnt != 8'd0) begin
                  gap_cnt  <= gap_cnt - 8'd1;
                  note_out <= 1'b0;
                end else begin
                  note_out <= 1'b1;
                  hold_cnt <= HOLD_INIT;
                  state    <= NOTE;
                end
              end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
              end else begin
                note_out <= 1'b0;
                if (note_count != 8'hFF) begin
                  note_count <= note_count + 8'd1;
                end
                if (!end_of_chart) begin
                  addr    <= addr_inc;
                  gap_cnt <= next_gap;
                  state   <= GAP;
                end else if (loop_en) begin
                  addr    <= '0;
                  gap_cnt <= first_gap;
                  state   <= GAP;
                end else begin
                  state   <= DONE;
                  step    <= 1'b0;
                  div_cnt <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                end
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
// tb_chart_sequencer
//   Directed bench for chart_sequencer. Two instances share clk/rst and the
//   write/control buses; sel routes the strobes and observed outputs:
//     sel=0 -> u_slow (TICK_DIV=2, CHART_DEPTH=64, BLOCK_LEN=5)
//     sel=1 -> u_fast (TICK_DIV=1, CHART_DEPTH=4,  BLOCK_LEN=5)
//   The note pattern is recorded as the value of note_out in the cycle after
//   each step strobe, i.e. the bit produced by that step.
module tb_chart_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [8:0] wr_data;
  logic       start;
  logic       stop;
  logic       loop_en;

  logic       a_note, a_step, a_busy, a_done;
  logic [7:0] a_cnt;
  logic       b_note, b_step, b_busy, b_done;
  logic [7:0] b_cnt;

  logic       note_o, step_o, busy_o, done_o;
  logic [7:0] cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chart_sequencer #(.CHART_DEPTH(64), .TICK_DIV(2), .BLOCK_LEN(5)) u_slow (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en & ~sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start & ~sel),
    .stop       (stop & ~sel),
    .loop_en    (loop_en),
    .note_out   (a_note),
    .step       (a_step),
    .busy       (a_busy),
    .done       (a_done),
    .note_count (a_cnt)
  );

  chart_sequencer #(.CHART_DEPTH(4), .TICK_DIV(1), .BLOCK_LEN(5)) u_fast (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en & sel),
    .wr_addr    (wr_addr[1:0]),
    .wr_data    (wr_data),
    .start      (start & sel),
    .stop       (stop & sel),
    .loop_en    (loop_en),
    .note_out   (b_note),
    .step       (b_step),
    .busy       (b_busy),
    .done       (b_done),
    .note_count (b_cnt)
  );

  assign note_o = sel ? b_note : a_note;
  assign step_o = sel ? b_step : a_step;
  assign busy_o = sel ? b_busy : a_busy;
  assign done_o = sel ? b_done : a_done;
  assign cnt_o  = sel ? b_cnt  : a_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input logic [5:0] a, input logic [8:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Returns at the negedge of the cycle after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for a step strobe, then returns the note bit it produced
  // and the number of cycles waited for the strobe.
  task automatic step_val(output logic v, output int n);
    n = 0;
    while (step_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (step_o !== 1'b1) begin
      v = 1'bx;
    end else begin
      @(negedge clk);
      v = note_o;
    end
  endtask

  // Walks a pattern of '0'/'1' characters; cad is the expected wait between
  // strobes after the first one.
  task automatic run_pattern(input string tag, input string exp, input int cad);
    logic v;
    int   n;
    for (int i = 0; i < exp.len(); i++) begin
      step_val(v, n);
      check($sformatf("%s cadence[%0d]", tag, i), n, (i == 0) ? 0 : cad);
      check($sformatf("%s note[%0d]", tag, i), v, (exp[i] == 8'h31));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic v;
    int   n;

    rst = 1'b1; sel = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state of both instances: {note, step, busy, done, count}.
    check("reset slow", {a_note, a_step, a_busy, a_done, a_cnt}, 32'h0);
    check("reset fast", {b_note, b_step, b_busy, b_done, b_cnt}, 32'h0);

    // Single note, TICK_DIV=2: gap 3 then a 5-step block.
    sel = 1'b0;
    write_entry(6'd0, 9'h103);
    pulse_start();
    check("single first cycle step", step_o, 1'b0);
    check("single first cycle busy", busy_o, 1'b1);
    @(negedge clk);
    run_pattern("single", "000111110", 1);
    check("single end {busy,done,count}", {busy_o, done_o, cnt_o}, {2'b01, 8'd1});

    // Three-entry sequence, TICK_DIV=1.
    sel = 1'b1;
    write_entry(6'd0, 9'h000);
    write_entry(6'd1, 9'h002);
    write_entry(6'd2, 9'h100);
    pulse_start();
    run_pattern("seq", "11111000111110111110", 0);
    check("seq end {busy,done,count}", {busy_o, done_o, cnt_o}, {2'b01, 8'd3});

    // Looping single entry: period 7 steps 0,11111,0.
    write_entry(6'd0, 9'h101);
    loop_en = 1'b1;
    pulse_start();
    for (int k = 1; k <= 60; k++) begin
      step_val(v, n);
      check($sformatf("loop cadence[%0d]", k), n, 0);
      check($sformatf("loop note[%0d]", k), v, ((k - 1) % 7 >= 1) && ((k - 1) % 7 <= 5));
      check($sformatf("loop {busy,done}[%0d]", k), {busy_o, done_o}, 2'b10);
      if (k == 56) check("loop count after 56 steps", cnt_o, 8'd8);
    end

    // Stop during the 3rd high step of the 9th note.
    check("pre-stop note high", note_o, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_en = 1'b0;
    check("stop {note,step,busy,done}", {note_o, step_o, busy_o, done_o}, 4'b0000);
    check("stop count held", cnt_o, 8'd8);

    // Full 4-entry chart, no end flags: ends by address wrap after 4 notes.
    // wr_en is held through the run; every write while busy must be ignored.
    write_entry(6'd0, 9'h000);
    write_entry(6'd1, 9'h001);
    write_entry(6'd2, 9'h000);
    write_entry(6'd3, 9'h002);
    pulse_start();
    check("restart count cleared", cnt_o, 8'd0);
    check("restart busy", busy_o, 1'b1);
    wr_en = 1'b1; wr_addr = 6'd1; wr_data = 9'h100;
    run_pattern("wrap", "111110011111011111000111110", 0);
    wr_en = 1'b0;
    check("wrap end {busy,done,count}", {busy_o, done_o, cnt_o}, {2'b01, 8'd4});

    // stop in DONE has no effect.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop in done {busy,done,count}", {busy_o, done_o, cnt_o}, {2'b01, 8'd4});

    // Reset during the gap of entry 1.
    pulse_start();
    run_pattern("pre-rst", "111110", 0);
    check("pre-rst {busy,count}", {busy_o, cnt_o}, {1'b1, 8'd1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid-gap outputs", {note_o, step_o, busy_o, done_o, cnt_o}, 32'h0);

    // start and stop together from IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start+stop {step,busy,done}", {step_o, busy_o, done_o}, 3'b000);
    @(negedge clk);
    check("start+stop later {step,busy,done}", {step_o, busy_o, done_o}, 3'b000);

    // Chart survives reset: the full pattern replays unchanged.
    pulse_start();
    run_pattern("retained", "111110011111011111000111110", 0);
    check("retained end {busy,done,count}", {busy_o, done_o, cnt_o}, {2'b01, 8'd4});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
